// File: rtl/ram_pkg.sv
// Shared definitions for the RAM8..RAM16K family and the block-copy engine:
// word width, per-size address widths and the copy FSM state encoding.
package ram_pkg;

  localparam int DATA_W    = 16;

  localparam int RAM8_AW   = 3;
  localparam int RAM64_AW  = 6;
  localparam int RAM512_AW = 9;
  localparam int RAM4K_AW  = 12;
  localparam int RAM16K_AW = 14;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD,
    WAIT,
    WR,
    FIN
  } copy_state_t;

endpackage

// File: rtl/copy_addr_gen.sv
// Source/destination pointers and remaining word count for ram_block_copy.
// load captures the request, setup picks the direction, step advances one word.
module copy_addr_gen #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              re,
  input  logic              load,
  input  logic              setup,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last,
  output logic              empty
);

  logic [ADDR_W:0]   cnt_q;
  logic              desc_q;
  logic              desc_now;
  logic [ADDR_W-1:0] off;

  // Overlap test uses the unwrapped end address so a copy that wraps past
  // the top of memory is never mistaken for a forward overlap.
  always_comb begin
    desc_now = (dst_ptr > src_ptr) &&
               ({1'b0, dst_ptr} < ({1'b0, src_ptr} + cnt_q));
    off      = ADDR_W'(cnt_q - (ADDR_W+1)'(1));
  end

  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt_q   <= '0;
      desc_q  <= 1'b0;
    end else if (load) begin
      src_ptr <= src;
      dst_ptr <= dst;
      cnt_q   <= len;
      desc_q  <= 1'b0;
    end else if (setup) begin
      desc_q <= desc_now;
      if (desc_now) begin
        src_ptr <= src_ptr + off;
        dst_ptr <= dst_ptr + off;
      end
    end else if (step) begin
      src_ptr <= desc_q ? src_ptr - ADDR_W'(1) : src_ptr + ADDR_W'(1);
      dst_ptr <= desc_q ? dst_ptr - ADDR_W'(1) : dst_ptr + ADDR_W'(1);
      cnt_q   <= cnt_q - (ADDR_W+1)'(1);
    end
  end

  assign last  = (cnt_q == (ADDR_W+1)'(1));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/ram_block_copy.sv
// Bus-master block copy engine driving a RAM8..RAM16K style port.
// Optional RAM_BLOCK_COPY_CHECKSUM_EN adds csum, the mod-2^16 sum of written words.
//
// state | meaning
// IDLE  | waiting for start; request captured on start
// SETUP | choose copy direction, set up pointers; len=0 goes straight to FIN
// RD    | issue read at source pointer
// WAIT  | hold read for RD_LAT cycles; latch DOut on the last one
// WR    | write latched word at destination pointer, step pointers
// FIN   | one-cycle done pulse
module ram_block_copy #(
  parameter int ADDR_W = ram_pkg::RAM16K_AW,
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              re,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0] csum,
`endif
  output logic              mem_e,
  output logic [DATA_W-1:0] mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w,
  output logic              mem_r,
  input  logic [DATA_W-1:0] mem_dout
);

  import ram_pkg::*;

  copy_state_t       state_q, state_d;
  logic [2:0]        wcnt_q;
  logic [DATA_W-1:0] data_q;
  logic              ag_load, ag_setup, ag_step;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic              last, empty;

  copy_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (clk),
    .re      (re),
    .load    (ag_load),
    .setup   (ag_setup),
    .step    (ag_step),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr),
    .last    (last),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge re) begin
    if (re) state_q <= IDLE;
    else    state_q <= state_d;
  end

  // Read-latency down-counter; DOut is taken when it reaches terminal count.
  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      wcnt_q <= '0;
      data_q <= '0;
    end else begin
      if (state_q == RD)
        wcnt_q <= 3'(RD_LAT - 1);
      else if (state_q == WAIT && wcnt_q != 3'd0)
        wcnt_q <= wcnt_q - 3'd1;
      if (state_q == WAIT && wcnt_q == 3'd0)
        data_q <= mem_dout;
    end
  end

  always_comb begin
    state_d  = state_q;
    ag_load  = 1'b0;
    ag_setup = 1'b0;
    ag_step  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    mem_e    = 1'b0;
    mem_r    = 1'b0;
    mem_w    = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ag_load = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        busy     = 1'b1;
        ag_setup = 1'b1;
        state_d  = empty ? FIN : RD;
      end
      RD: begin
        busy     = 1'b1;
        mem_e    = 1'b1;
        mem_r    = 1'b1;
        mem_addr = src_ptr;
        state_d  = WAIT;
      end
      WAIT: begin
        busy     = 1'b1;
        mem_e    = 1'b1;
        mem_r    = 1'b1;
        mem_addr = src_ptr;
        if (wcnt_q == 3'd0) state_d = WR;
      end
      WR: begin
        busy     = 1'b1;
        mem_e    = 1'b1;
        mem_w    = 1'b1;
        mem_addr = dst_ptr;
        mem_din  = data_q;
        ag_step  = 1'b1;
        state_d  = last ? FIN : RD;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
  always_ff @(posedge clk or posedge re) begin
    if (re)                  csum <= '0;
    else if (state_q == SETUP) csum <= '0;
    else if (state_q == WR)    csum <= csum + data_q;
  end
`endif

endmodule

// File: tb/tb_ram_block_copy.sv
// Self-checking bench for ram_block_copy: behavioural RAM with RD_LAT read
// latency, memmove-style reference model, directed and randomized copies.
module tb_ram_block_copy;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 3;
  localparam int N      = 1 << ADDR_W;
  localparam int MASK   = N - 1;
  localparam int CPW    = RD_LAT + 2;

  logic              clk = 1'b0;
  logic              re = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src = '0;
  logic [ADDR_W-1:0] dst = '0;
  logic [ADDR_W:0]   len = '0;
  logic              busy, done, mem_e, mem_w, mem_r;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_addr;
`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  always #5 clk = ~clk;

  ram_block_copy #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .re       (re),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .busy     (busy),
    .done     (done),
`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
    .csum     (csum),
`endif
    .mem_e    (mem_e),
    .mem_din  (mem_din),
    .mem_addr (mem_addr),
    .mem_w    (mem_w),
    .mem_r    (mem_r),
    .mem_dout (mem_dout)
  );

  // Behavioural RAM: data appears RD_LAT cycles after the first cycle of a
  // read and only then; every other cycle DOut carries random junk.
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] pipe [RD_LAT];
  logic              pv [RD_LAT] = '{default: 1'b0};
  logic              ram_prev_r = 1'b0;
  logic              init_done = 1'b0;
  logic [DATA_W-1:0] junk = '0;
  logic              pl_we = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  function automatic logic [DATA_W-1:0] seed_word(input int a);
    return DATA_W'(a * 40503 + 4660) ^ 16'h5a5a;
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < N; i++) mem[i] <= seed_word(i);
      init_done <= 1'b1;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_e && mem_w) begin
      mem[mem_addr] <= mem_din;
    end
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pipe[i] <= pipe[i-1];
      pv[i]   <= pv[i-1];
    end
    pipe[0]    <= mem[mem_addr];
    pv[0]      <= mem_e && mem_r && !ram_prev_r;
    ram_prev_r <= mem_e && mem_r;
    junk       <= 16'($urandom);
  end

  assign mem_dout = pv[RD_LAT-1] ? pipe[RD_LAT-1] : junk;

  // Monitor, sampled on the falling edge.
  int                cyc = 0;
  logic [ADDR_W-1:0] rd_q [$];
  logic [ADDR_W-1:0] wa_q [$];
  logic [DATA_W-1:0] wd_q [$];
  int                e_cnt = 0, viol_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic              mon_prev_r = 1'b0;
  logic [DATA_W-1:0] csum_done = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_e) e_cnt++;
    if (mem_r && !mon_prev_r) rd_q.push_back(mem_addr);
    mon_prev_r = mem_r;
    if (mem_w) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_din);
    end
    if ((mem_w && mem_r) || ((mem_w || mem_r) && !mem_e) || (!mem_w && mem_din != '0))
      viol_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
      csum_done = csum;
`endif
    end
  end

  logic [DATA_W-1:0] ref_mem [N];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input logic [DATA_W-1:0] v);
    @(posedge clk); #1;
    pl_we = 1'b1; pl_addr = ADDR_W'(a); pl_data = v;
    @(posedge clk); #1;
    pl_we = 1'b0;
    ref_mem[a & MASK] = v;
  endtask

  task automatic run_copy(input string nm, input int s, input int d, input int l, input bit poke);
    logic [DATA_W-1:0] tmp [$];
    int  rd0, wr0, e0, v0, dc0, t0, idx, sum;
    bit  desc;
    desc = (d > s) && (d < s + l);
    for (int i = 0; i < l; i++) tmp.push_back(ref_mem[(s + i) & MASK]);
    rd0 = rd_q.size(); wr0 = wa_q.size(); e0 = e_cnt; v0 = viol_cnt; dc0 = done_cnt;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b1;
    src = ADDR_W'(s); dst = ADDR_W'(d); len = (ADDR_W+1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (2) @(posedge clk); #1;
      start = 1'b1; src = ADDR_W'($urandom); dst = ADDR_W'($urandom); len = 15'd5;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < l * CPW + 50; k++) begin
      if (done_cnt != dc0) break;
      @(negedge clk); #1;
    end
    check({nm, ".done_seen"}, done_cnt - dc0, 1);
    check({nm, ".done_cycle"}, done_cyc - t0, 2 + l * CPW);
    check({nm, ".busy_at_done"}, busy, 0);
    repeat (2) @(negedge clk); #1;
    check({nm, ".done_pulses"}, done_cnt - dc0, 1);
    check({nm, ".busy_after"}, busy, 0);
    check({nm, ".protocol"}, viol_cnt - v0, 0);
    check({nm, ".n_reads"}, rd_q.size() - rd0, l);
    check({nm, ".n_writes"}, wa_q.size() - wr0, l);
    if (l == 0) check({nm, ".mem_e_cycles"}, e_cnt - e0, 0);
    sum = 0;
    for (int k = 0; k < l; k++) begin
      idx = desc ? l - 1 - k : k;
      sum += int'(tmp[idx]);
      if (rd0 + k < rd_q.size())
        check({nm, ".rd_addr"}, rd_q[rd0 + k], (s + idx) & MASK);
      if (wr0 + k < wa_q.size()) begin
        check({nm, ".wr_addr"}, wa_q[wr0 + k], (d + idx) & MASK);
        check({nm, ".wr_data"}, wd_q[wr0 + k], tmp[idx]);
      end
    end
`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
    if (l > 0) check({nm, ".csum"}, csum_done, sum & 16'hFFFF);
`endif
    for (int i = 0; i < l; i++) begin
      check({nm, ".mem"}, mem[(d + i) & MASK], tmp[i]);
      ref_mem[(d + i) & MASK] = tmp[i];
    end
  endtask

  initial begin
    int s, d, l, wr_seen, dc0;
    logic [DATA_W-1:0] old [6];
    logic [DATA_W-1:0] sv [2];

    for (int i = 0; i < N; i++) ref_mem[i] = seed_word(i);

    repeat (3) @(posedge clk); #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.mem_e", mem_e, 0);
    check("rst.mem_r", mem_r, 0);
    check("rst.mem_w", mem_w, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.mem_din", mem_din, 0);
`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
    check("rst.csum", csum, 0);
`endif
    re = 1'b0;
    repeat (2) @(posedge clk); #1;

    for (int i = 0; i < 8; i++) preload(i, 16'(i + 1));
    run_copy("asc", 0, 100, 8, 1'b0);

    preload(10, 16'hA); preload(11, 16'hB); preload(12, 16'hC); preload(13, 16'hD);
    run_copy("ovl_desc", 10, 12, 4, 1'b0);

    run_copy("len0", 50, 60, 0, 1'b0);
    run_copy("wrap", 16'h3FFE, 16'h1000, 4, 1'b0);

`ifdef RAM_BLOCK_COPY_CHECKSUM_EN
    preload(16'h500, 16'hFFFF); preload(16'h501, 16'h0002);
    run_copy("csum", 16'h500, 16'h600, 2, 1'b0);
    check("csum.value", csum_done, 16'h0001);
`endif

    run_copy("busy_start", 400, 420, 6, 1'b1);

    // Reset asserted in the middle of the third write.
    s = 200; d = 300;
    for (int i = 0; i < 6; i++) old[i] = ref_mem[d + i];
    sv[0] = ref_mem[s]; sv[1] = ref_mem[s + 1];
    dc0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; src = ADDR_W'(s); dst = ADDR_W'(d); len = 15'd6;
    @(posedge clk); #1;
    start = 1'b0;
    wr_seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (mem_w) wr_seen++;
      if (wr_seen == 3) break;
    end
    check("abort.third_wr", wr_seen, 3);
    re = 1'b1;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.mem_e", mem_e, 0);
    check("abort.mem_r", mem_r, 0);
    check("abort.mem_w", mem_w, 0);
    check("abort.mem_addr", mem_addr, 0);
    check("abort.mem_din", mem_din, 0);
    repeat (3) @(posedge clk); #1;
    re = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("abort.no_done", done_cnt - dc0, 0);
    check("abort.idle", busy, 0);
    check("abort.mem0", mem[d], sv[0]);
    check("abort.mem1", mem[d + 1], sv[1]);
    for (int i = 3; i < 6; i++) check("abort.untouched", mem[d + i], old[i]);
    ref_mem[d] = sv[0]; ref_mem[d + 1] = sv[1];

    for (int n = 0; n < 10; n++) begin
      s = $urandom_range(1000, N - 100);
      l = $urandom_range(1, 24);
      if ($urandom_range(0, 1) == 1) d = s + $urandom_range(0, 2 * l) - l;
      else                           d = $urandom_range(1000, N - 100);
      run_copy("rand", s, d, l, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
